mcast_rr_scheduler: RTL and testbench

- Crossbar scheduler for the 4-port switch. It sits between the per-port ingress FIFOs and the four output muxes.
- Each cycle it takes the FIFO head-valid requests and their destination masks (unicast or multicast). It grants a conflict-free set of inputs using a single rotating-priority pointer.
- It drives the FIFO pop grants, the per-output mux selects and the per-output active flags as registered outputs.
- Multicast is all-or-nothing: an input is granted only when every output in its mask is free.

---
 rtl/packet_pkg.sv | 30 +++
 rtl/rr_mask_alloc.sv | 47 ++++
 rtl/mcast_rr_scheduler.sv | 102 ++++++++++
 tb/tb_mcast_rr_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared switch definitions: port count, word width, mask/select types and
// the rotating-pointer advance helper used by the crossbar scheduler.
package packet_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 32;
    localparam int SEL_WIDTH  = $clog2(ADDR_WIDTH);

    typedef logic [ADDR_WIDTH-1:0] dst_mask_t;
    typedef logic [SEL_WIDTH-1:0]  sel_t;

    // New pointer = one past the first granted input in visit order from ptr.
    // With no grant the pointer holds, so a quiet cycle never shifts priority.
    function automatic sel_t ptr_after(sel_t ptr, dst_mask_t grant);
        sel_t nxt;
        logic found;
        int   idx;
        nxt   = ptr;
        found = 1'b0;
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            idx = (int'(ptr) + k) % ADDR_WIDTH;
            if (!found && grant[idx]) begin
                nxt   = sel_t'((idx + 1) % ADDR_WIDTH);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_mask_alloc.sv
// Combinational greedy allocator. Walks the inputs from the priority pointer
// and grants every eligible head whose whole effective mask is still free.
// Heads with an empty effective mask are granted as flushes and raise drop.
module rr_mask_alloc
    import packet_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0]                  eligible_i,
    input  logic [ADDR_WIDTH-1:0][ADDR_WIDTH-1:0]  eff_i,
    input  logic [SEL_WIDTH-1:0]                   ptr_i,
    output logic [ADDR_WIDTH-1:0]                  grant_o,
    output logic [ADDR_WIDTH-1:0][SEL_WIDTH-1:0]   sel_o,
    output logic [ADDR_WIDTH-1:0]                  active_o,
    output logic                                   drop_o
);

    logic [ADDR_WIDTH-1:0] claimed;
    int                    idx;

    // Greedy visit in pointer order; multicast is all-or-nothing.
    always_comb begin
        grant_o  = '0;
        sel_o    = '0;
        active_o = '0;
        drop_o   = 1'b0;
        claimed  = '0;
        idx      = 0;
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            idx = (int'(ptr_i) + k) % ADDR_WIDTH;
            if (eligible_i[idx]) begin
                if (eff_i[idx] == '0) begin
                    grant_o[idx] = 1'b1;
                    drop_o       = 1'b1;
                end else if ((eff_i[idx] & claimed) == '0) begin
                    grant_o[idx] = 1'b1;
                    claimed      = claimed | eff_i[idx];
                    for (int j = 0; j < ADDR_WIDTH; j++) begin
                        if (eff_i[idx][j]) begin
                            sel_o[j]    = sel_t'(idx);
                            active_o[j] = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mcast_rr_scheduler.sv
// 4-port crossbar scheduler. Arbitrates on this cycle's FIFO heads and
// presents pops, mux selects and output-active flags from flops next cycle,
// aligned with the show-ahead head word. A head popped this cycle is blacked
// out from the next arbitration because its request is still the stale one.
module mcast_rr_scheduler
    import packet_pkg::*;
#(
    parameter int NUM_PORTS = ADDR_WIDTH,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] port_reqs,
    input  logic [NUM_PORTS-1:0] port0_dst,
    input  logic [NUM_PORTS-1:0] port1_dst,
    input  logic [NUM_PORTS-1:0] port2_dst,
    input  logic [NUM_PORTS-1:0] port3_dst,
    input  logic [NUM_PORTS-1:0] out_enable,
    output logic [NUM_PORTS-1:0] grant_bus,
    output logic [SEL_W-1:0]     mux_sel0,
    output logic [SEL_W-1:0]     mux_sel1,
    output logic [SEL_W-1:0]     mux_sel2,
    output logic [SEL_W-1:0]     mux_sel3,
    output logic                 active0,
    output logic                 active1,
    output logic                 active2,
    output logic                 active3,
    output logic                 drop_err
);

    logic [NUM_PORTS-1:0]            grant_q, grant_d;
    logic [NUM_PORTS-1:0][SEL_W-1:0] sel_q, sel_d;
    logic [NUM_PORTS-1:0]            active_q, active_d;
    logic                            drop_q, drop_d;
    logic [SEL_W-1:0]                ptr_q, ptr_d;

    logic [NUM_PORTS-1:0]                eligible;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] eff;
    logic [NUM_PORTS-1:0]                grant_c;
    logic [NUM_PORTS-1:0][SEL_W-1:0]     sel_c;
    logic [NUM_PORTS-1:0]                active_c;
    logic                                drop_c;

    // Eligibility excludes last cycle's pops; masks lose disabled outputs.
    always_comb begin
        eligible = port_reqs & ~grant_q;
        eff[0]   = port0_dst & out_enable;
        eff[1]   = port1_dst & out_enable;
        eff[2]   = port2_dst & out_enable;
        eff[3]   = port3_dst & out_enable;
    end

    rr_mask_alloc u_alloc (
        .eligible_i (eligible),
        .eff_i      (eff),
        .ptr_i      (ptr_q),
        .grant_o    (grant_c),
        .sel_o      (sel_c),
        .active_o   (active_c),
        .drop_o     (drop_c)
    );

    // Next-state: unclaimed outputs keep their last select.
    always_comb begin
        grant_d  = grant_c;
        active_d = active_c;
        drop_d   = drop_c;
        ptr_d    = ptr_after(ptr_q, grant_c);
        for (int j = 0; j < NUM_PORTS; j++) begin
            sel_d[j] = active_c[j] ? sel_c[j] : sel_q[j];
        end
    end

    // All outputs, the pointer and the blackout (grant_q) update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            sel_q    <= '0;
            active_q <= '0;
            drop_q   <= 1'b0;
            ptr_q    <= '0;
        end else begin
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            active_q <= active_d;
            drop_q   <= drop_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant_bus = grant_q;
    assign mux_sel0  = sel_q[0];
    assign mux_sel1  = sel_q[1];
    assign mux_sel2  = sel_q[2];
    assign mux_sel3  = sel_q[3];
    assign active0   = active_q[0];
    assign active1   = active_q[1];
    assign active2   = active_q[2];
    assign active3   = active_q[3];
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_mcast_rr_scheduler.sv
// Scoreboard bench for the crossbar scheduler: the driver pushes a
// hand-computed expected response per applied vector; the monitor pops one
// entry after each clock edge and compares all registered outputs.
module tb_mcast_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] port_reqs, port0_dst, port1_dst, port2_dst, port3_dst, out_enable;
    logic [3:0] grant_bus;
    logic [1:0] mux_sel0, mux_sel1, mux_sel2, mux_sel3;
    logic       active0, active1, active2, active3;
    logic       drop_err;

    typedef struct {
        int         id;
        logic [3:0] g;
        logic [7:0] s;
        logic [3:0] a;
        logic       d;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    mcast_rr_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_reqs  (port_reqs),
        .port0_dst  (port0_dst),
        .port1_dst  (port1_dst),
        .port2_dst  (port2_dst),
        .port3_dst  (port3_dst),
        .out_enable (out_enable),
        .grant_bus  (grant_bus),
        .mux_sel0   (mux_sel0),
        .mux_sel1   (mux_sel1),
        .mux_sel2   (mux_sel2),
        .mux_sel3   (mux_sel3),
        .active0    (active0),
        .active1    (active1),
        .active2    (active2),
        .active3    (active3),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sels();
        return {mux_sel3, mux_sel2, mux_sel1, mux_sel0};
    endfunction

    function automatic logic [3:0] acts();
        return {active3, active2, active1, active0};
    endfunction

    // Monitor: every registered result is checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if ({grant_bus, sels(), acts(), drop_err} !== {e.g, e.s, e.a, e.d}) begin
                    miscompares++;
                    $display("FAIL vec%0d: got grant=%b sel=%h act=%b drop=%b, want grant=%b sel=%h act=%b drop=%b",
                             e.id, grant_bus, sels(), acts(), drop_err, e.g, e.s, e.a, e.d);
                end
            end
        end
    end

    task automatic vec(input int id, input logic [3:0] req, input logic [3:0] d0,
                       input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                       input logic [3:0] en, input logic [3:0] eg, input logic [7:0] es,
                       input logic [3:0] ea, input logic ed);
        exp_t e;
        @(negedge clk);
        port_reqs  = req;
        port0_dst  = d0;
        port1_dst  = d1;
        port2_dst  = d2;
        port3_dst  = d3;
        out_enable = en;
        e.id = id; e.g = eg; e.s = es; e.a = ea; e.d = ed;
        q.push_back(e);
    endtask

    task automatic check_clear(input string name);
        vectors++;
        if ({grant_bus, sels(), acts(), drop_err} !== 17'd0) begin
            miscompares++;
            $display("FAIL %s: got grant=%b sel=%h act=%b drop=%b, want all zero",
                     name, grant_bus, sels(), acts(), drop_err);
        end
    endtask

    // Driver: directed vectors, sel packed as {sel3,sel2,sel1,sel0}.
    initial begin
        int         w;
        logic [7:0] s;
        int         guard;
        rst_n = 1'b0;
        port_reqs = '0; port0_dst = '0; port1_dst = '0; port2_dst = '0; port3_dst = '0;
        out_enable = 4'b1111;
        repeat (2) @(negedge clk);
        check_clear("reset_state");
        rst_n = 1'b1;

        //  id  req      d0       d1       d2       d3       en       grant    sel    act      drop
        vec(1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'h00, 4'b0000, 0);
        vec(2,  4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 8'h00, 4'b0100, 0);
        vec(3,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'h00, 4'b0000, 0);
        vec(4,  4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b1000, 8'h03, 4'b0001, 0);
        // conflict on output 3 with ptr=0, then blackout hands it to input 1
        vec(5,  4'b0011, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 8'h03, 4'b1000, 0);
        vec(6,  4'b0011, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1111, 4'b0010, 8'h43, 4'b1000, 0);
        vec(7,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 8'h40, 4'b0001, 0);
        vec(8,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'h40, 4'b0000, 0);
        // multicast blocked with ptr=1: no partial delivery, granted next cycle
        vec(9,  4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 4'b0010, 8'h44, 4'b0010, 0);
        vec(10, 4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 8'h40, 4'b0011, 0);
        vec(11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'h40, 4'b0000, 0);
        // parallel unicast, all four granted at once
        vec(12, 4'b1111, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1111, 4'b1111, 8'h93, 4'b1111, 0);
        vec(13, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'h93, 4'b0000, 0);
        // zero-mask flush, blackout, then fully-disabled-mask flush
        vec(14, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 8'h93, 4'b0000, 1);
        vec(15, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 8'h93, 4'b0000, 0);
        vec(16, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b1110, 4'b0100, 8'h93, 4'b0000, 1);
        vec(17, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'h93, 4'b0000, 0);

        // fairness: all four on output 0, ptr=3 -> winners 3,0,1,2,3,...
        for (int c = 0; c < 16; c++) begin
            w = (3 + c) % 4;
            s = 8'h90 | 8'(w);
            vec(100 + c, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1111,
                4'(1 << w), s, 4'b0001, 0);
        end

        // grant in flight, then async reset before the next edge
        vec(200, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 8'h90, 4'b0001, 0);
        @(posedge clk);
        #4;
        port_reqs = '0;
        rst_n = 1'b0;
        #1;
        check_clear("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        // pointer back at 0 after reset, so input 0 wins over input 1
        vec(201, 4'b0011, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 8'h00, 4'b0100, 0);
        vec(202, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'h00, 4'b0000, 0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
